// File: rtl/fifo_pkg.sv
// Gray/binary pointer helpers shared by the write- and read-side FIFO pointer blocks.
// Values are zero-extended into ptr_word_t, so one definition serves any pointer width up to PTR_MAX_W.
package fifo_pkg;

  localparam int unsigned PTR_MAX_W = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Prefix XOR from the MSB: bin[i] = ^gray[MSB:i]; the zero upper bits make this width-agnostic.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray);
    ptr_word_t bin;
    bin = gray;
    for (int i = 1; i < int'(PTR_MAX_W); i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ptr.sv
// Write-side pointer and flag logic for an async FIFO: binary/Gray write pointer,
// full / almost_full / occupancy against the synchronized read pointer, and ack/overflow pulses.
module fifo_wr_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH         = 4,
  parameter int unsigned ALMOST_FULL_THRESH = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_sync,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  wr_ack,
  output logic                  overflow
);

  localparam int unsigned PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wr_bin;
  logic [PTR_W-1:0] wr_bin_next_c;
  logic [PTR_W-1:0] wr_gray_next_c;
  logic [PTR_W-1:0] rd_bin_c;
  logic [PTR_W-1:0] rd_gray_full_c;
  logic [PTR_W-1:0] count_next_c;
  logic             wr_accept_c;
  logic             full_next_c;
  logic             almost_full_next_c;

  // Next-state pointer and flags, all derived from the post-write pointer.
  always_comb begin
    wr_accept_c        = 1'b0;
    wr_bin_next_c      = wr_bin;
    wr_gray_next_c     = '0;
    rd_bin_c           = '0;
    rd_gray_full_c     = '0;
    count_next_c       = '0;
    full_next_c        = 1'b0;
    almost_full_next_c = 1'b0;

    wr_accept_c    = wr_en & ~full;
    wr_bin_next_c  = wr_bin + PTR_W'(wr_accept_c);
    wr_gray_next_c = PTR_W'(bin2gray(PTR_MAX_W'(wr_bin_next_c)));
    rd_bin_c       = PTR_W'(gray2bin(PTR_MAX_W'(rd_ptr_gray_sync)));
    count_next_c   = wr_bin_next_c - rd_bin_c;

    // Full when the write pointer is exactly one lap ahead: Gray form inverts the two MSBs.
    rd_gray_full_c     = rd_ptr_gray_sync ^ (PTR_W'(3) << (PTR_W - 2));
    full_next_c        = (wr_gray_next_c == rd_gray_full_c);
    almost_full_next_c = (count_next_c >= PTR_W'(ALMOST_FULL_THRESH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bin      <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_next_c;
      wr_ptr_gray <= wr_gray_next_c;
      full        <= full_next_c;
      almost_full <= almost_full_next_c;
      wr_count    <= count_next_c;
      wr_ack      <= wr_accept_c;
      overflow    <= wr_en & full;
    end
  end

  assign wr_addr = wr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// Scoreboard bench for fifo_wr_ptr (ADDR_WIDTH=4, ALMOST_FULL_THRESH=14): the driver pushes
// expected post-edge outputs, a monitor pops and compares them, plus directed hand-value checks.
module tb_fifo_wr_ptr;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [4:0] rd_ptr_gray_sync;
  logic [4:0] wr_ptr_gray;
  logic [3:0] wr_addr;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       wr_ack;
  logic       overflow;

  fifo_wr_ptr #(.ADDR_WIDTH(4), .ALMOST_FULL_THRESH(14)) dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .wr_ptr_gray      (wr_ptr_gray),
    .wr_addr          (wr_addr),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count),
    .wr_ack           (wr_ack),
    .overflow         (overflow)
  );

  typedef struct {
    logic       rst;
    logic       ack;
    logic       ovf;
    logic       full;
    logic       af;
    logic [4:0] count;
    logic [4:0] gray;
    logic [3:0] addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Bench model state: binary write pointer and the registered full flag.
  int   m_bin  = 0;
  logic m_full = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] to_gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // Drive one cycle and push the outputs expected right after the next edge.
  task automatic step(input logic r, input logic we, input int rdb);
    exp_t e;
    int   occ;
    @(negedge clk);
    rst              = r;
    wr_en            = we;
    rd_ptr_gray_sync = to_gray(rdb);
    e.rst = r;
    if (r) begin
      m_bin  = 0;
      m_full = 1'b0;
      e.ack = 1'b0; e.ovf = 1'b0; e.full = 1'b0; e.af = 1'b0;
      e.count = '0; e.gray = '0; e.addr = '0;
    end else begin
      e.ack  = we && !m_full;
      e.ovf  = we && m_full;
      m_bin  = (m_bin + (e.ack ? 1 : 0)) % 32;
      occ    = (m_bin - (rdb % 32) + 32) % 32;
      m_full = (occ == 16);
      e.full = m_full;
      e.af   = (occ >= 14);
      e.count = 5'(occ);
      e.gray  = to_gray(m_bin);
      e.addr  = 4'(m_bin % 16);
    end
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: compares every presented post-edge response and the one-bit Gray step rule.
  initial begin : monitor
    exp_t       e;
    logic [4:0] prev_gray;
    prev_gray = '0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wr_ack",      int'(wr_ack),      int'(e.ack));
        chk("overflow",    int'(overflow),    int'(e.ovf));
        chk("full",        int'(full),        int'(e.full));
        chk("almost_full", int'(almost_full), int'(e.af));
        chk("wr_count",    int'(wr_count),    int'(e.count));
        chk("wr_ptr_gray", int'(wr_ptr_gray), int'(e.gray));
        chk("wr_addr",     int'(wr_addr),     int'(e.addr));
        chk("ack_ovf_excl", int'(wr_ack & overflow), 0);
        if (!e.rst) chk("gray_one_bit", int'($countones(wr_ptr_gray ^ prev_gray) <= 1), 1);
        prev_gray = wr_ptr_gray;
      end
    end
  end

  initial begin : driver
    int acks;
    int wtotal;
    int rdb;
    int seen_full;
    rst = 1'b1;
    wr_en = 1'b0;
    rd_ptr_gray_sync = '0;

    // Reset with wr_en high: request must be ignored.
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b1, 0);
    chk("reset_ack", int'(wr_ack), 0);
    chk("reset_gray", int'(wr_ptr_gray), 0);

    // Fill from empty.
    acks = 0;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 1'b1, 0);
      acks += int'(wr_ack);
      if (k == 13) chk("af_before_14", int'(almost_full), 0);
      if (k == 14) chk("af_at_14", int'(almost_full), 1);
      if (k == 15) chk("not_full_15", int'(full), 0);
    end
    chk("fill_acks", acks, 16);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(wr_count), 16);
    chk("fill_gray", int'(wr_ptr_gray), 5'b11000);

    // Write while full is rejected.
    step(1'b0, 1'b1, 0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_no_ack", int'(wr_ack), 0);
    chk("ovf_gray_hold", int'(wr_ptr_gray), 5'b11000);
    chk("ovf_addr_hold", int'(wr_addr), 0);
    step(1'b0, 1'b0, 0);
    chk("ovf_one_cycle", int'(overflow), 0);

    // Reader advances to 4 (Gray 00110).
    step(1'b0, 1'b0, 4);
    chk("drain_full", int'(full), 0);
    chk("drain_count", int'(wr_count), 12);
    chk("drain_af", int'(almost_full), 0);

    // Streaming with the reader 8 behind, across the pointer wrap.
    step(1'b1, 1'b0, 0);
    wtotal = 0;
    seen_full = 0;
    for (int k = 1; k <= 40; k++) begin
      rdb = (wtotal >= 8) ? (wtotal - 8) % 32 : 0;
      step(1'b0, 1'b1, rdb);
      wtotal++;
      seen_full += int'(full);
      if (k == 31) begin
        chk("wrap_gray_31", int'(wr_ptr_gray), 5'b10000);
        chk("wrap_addr_31", int'(wr_addr), 15);
      end
      if (k == 32) begin
        chk("wrap_gray_0", int'(wr_ptr_gray), 5'b00000);
        chk("wrap_addr_0", int'(wr_addr), 0);
        chk("wrap_ack", int'(wr_ack), 1);
      end
    end
    chk("stream_never_full", seen_full, 0);

    // Mid-operation reset with wr_en held high.
    step(1'b1, 1'b0, 0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 0);
    chk("pre_rst_addr", int'(wr_addr), 10);
    step(1'b1, 1'b1, 0);
    chk("rst_ack", int'(wr_ack), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_count", int'(wr_count), 0);
    chk("rst_gray", int'(wr_ptr_gray), 0);
    step(1'b0, 1'b1, 0);
    chk("resume_ack", int'(wr_ack), 1);
    chk("resume_addr", int'(wr_addr), 1);
    step(1'b0, 1'b0, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
